// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response/burst encodings, responder FSM states and burst address stepping
package axi_pkg;
   typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_e;
   typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
   function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size, input logic [1:0] burst);
      return (burst == BURST_FIXED) ? addr : addr + (64'd1 << size);
   endfunction
endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 bundle between a master and the memory responder
interface axi_mem_responder_if #(
   parameter int ID_W = 1,
   parameter int ADDR_W = 36
);
   logic [ID_W-1:0] awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0] awlen;
   logic [2:0] awsize;
   logic [1:0] awburst;
   logic awlock;
   logic [3:0] awcache;
   logic [2:0] awprot;
   logic [3:0] awqos;
   logic awvalid;
   logic awready;
   logic [63:0] wdata;
   logic [7:0] wstrb;
   logic wlast;
   logic wvalid;
   logic wready;
   logic [ID_W-1:0] bid;
   logic [1:0] bresp;
   logic bvalid;
   logic bready;
   logic [ID_W-1:0] arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0] arlen;
   logic [2:0] arsize;
   logic [1:0] arburst;
   logic arlock;
   logic [3:0] arcache;
   logic [2:0] arprot;
   logic [3:0] arqos;
   logic arvalid;
   logic arready;
   logic [ID_W-1:0] rid;
   logic [63:0] rdata;
   logic [1:0] rresp;
   logic rlast;
   logic rvalid;
   logic rready;
   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input wdata, wstrb, wlast, wvalid, bready,
      input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
      input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_mem_array.sv
// axi_mem_array: 64-bit byte-enabled RAM with one write port and one registered read port (read-first)
module axi_mem_array #(
   parameter int DEPTH_LOG2 = 12
) (
   input logic clk,
   input logic we,
   input logic [DEPTH_LOG2-1:0] waddr,
   input logic [63:0] wdata,
   input logic [7:0] wstrb,
   input logic re,
   input logic [DEPTH_LOG2-1:0] raddr,
   output logic [63:0] rdata
);
   logic [63:0] mem [1 << DEPTH_LOG2];
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      for (int i = 0; i < 8; i++)
         if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
   end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave serving INCR/FIXED bursts from an on-chip 64-bit RAM window
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int ID_W = 1,
   parameter int ADDR_W = 36,
   parameter logic [ADDR_W-1:0] BASE = 36'h8_0000_0000,
   parameter int DEPTH_LOG2 = 12
) (
   input logic aclk,
   input logic aresetn,
   axi_mem_responder_if.slave s_axi
);
   localparam int LO = DEPTH_LOG2 + 3;
   wstate_e ws;
   rstate_e rs;
   logic [ID_W-1:0] w_id, r_id;
   logic [ADDR_W-1:0] w_addr, r_addr;
   logic [7:0] w_len, w_cnt, r_len, r_cnt;
   logic [2:0] w_size, r_size;
   logic [1:0] w_burst, r_burst;
   logic w_err, r_err, w_end, we, re, unused;
   logic [63:0] ram_q;
   function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [2:0] size, input logic [1:0] burst);
      return a[ADDR_W-1:LO] != BASE[ADDR_W-1:LO] || burst == BURST_WRAP || size > 3'd3;
   endfunction
   assign unused = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                     s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
   assign w_end = s_axi.wlast || w_cnt == w_len;
   assign we = ws == W_DATA && s_axi.wvalid && !w_err;
   assign re = rs == R_ADDR;
   assign s_axi.rdata = (s_axi.rvalid && !r_err) ? ram_q : 64'd0;
   axi_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk(aclk),
      .we(we),
      .waddr(w_addr[LO-1:3]),
      .wdata(s_axi.wdata),
      .wstrb(s_axi.wstrb),
      .re(re),
      .raddr(r_addr[LO-1:3]),
      .rdata(ram_q)
   );
   // write side: the response reflects only how the final beat lined up wlast against len
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ws <= W_IDLE;
         s_axi.awready <= 1'b1;
         s_axi.wready <= 1'b0;
         s_axi.bvalid <= 1'b0;
         s_axi.bid <= '0;
         s_axi.bresp <= '0;
         w_id <= '0;
         w_addr <= '0;
         w_len <= '0;
         w_cnt <= '0;
         w_size <= '0;
         w_burst <= '0;
         w_err <= 1'b0;
      end else begin
         case (ws)
            W_IDLE: if (s_axi.awvalid) begin
               ws <= W_DATA;
               s_axi.awready <= 1'b0;
               s_axi.wready <= 1'b1;
               w_id <= s_axi.awid;
               w_addr <= s_axi.awaddr;
               w_len <= s_axi.awlen;
               w_size <= s_axi.awsize;
               w_burst <= s_axi.awburst;
               w_err <= addr_err(s_axi.awaddr, s_axi.awsize, s_axi.awburst);
               w_cnt <= '0;
            end
            W_DATA: if (s_axi.wvalid) begin
               w_addr <= ADDR_W'(next_addr(64'(w_addr), w_size, w_burst));
               w_cnt <= w_cnt + 8'd1;
               if (w_end) begin
                  ws <= W_RESP;
                  s_axi.wready <= 1'b0;
                  s_axi.bvalid <= 1'b1;
                  s_axi.bid <= w_id;
                  s_axi.bresp <= w_err ? RESP_DECERR : (s_axi.wlast != (w_cnt == w_len)) ? RESP_SLVERR : RESP_OKAY;
               end
            end
            W_RESP: if (s_axi.bready) begin
               ws <= W_IDLE;
               s_axi.bvalid <= 1'b0;
               s_axi.awready <= 1'b1;
            end
            default: ws <= W_IDLE;
         endcase
      end
   end
   // read side: every beat passes through R_ADDR so the array output is fresh and then frozen
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rs <= R_IDLE;
         s_axi.arready <= 1'b1;
         s_axi.rvalid <= 1'b0;
         s_axi.rid <= '0;
         s_axi.rresp <= '0;
         s_axi.rlast <= 1'b0;
         r_id <= '0;
         r_addr <= '0;
         r_len <= '0;
         r_cnt <= '0;
         r_size <= '0;
         r_burst <= '0;
         r_err <= 1'b0;
      end else begin
         case (rs)
            R_IDLE: if (s_axi.arvalid) begin
               rs <= R_ADDR;
               s_axi.arready <= 1'b0;
               r_id <= s_axi.arid;
               r_addr <= s_axi.araddr;
               r_len <= s_axi.arlen;
               r_size <= s_axi.arsize;
               r_burst <= s_axi.arburst;
               r_err <= addr_err(s_axi.araddr, s_axi.arsize, s_axi.arburst);
               r_cnt <= '0;
            end
            R_ADDR: begin
               rs <= R_DATA;
               s_axi.rvalid <= 1'b1;
               s_axi.rid <= r_id;
               s_axi.rresp <= r_err ? RESP_DECERR : RESP_OKAY;
               s_axi.rlast <= r_cnt == r_len;
            end
            R_DATA: if (s_axi.rready) begin
               s_axi.rvalid <= 1'b0;
               s_axi.rlast <= 1'b0;
               rs <= s_axi.rlast ? R_IDLE : R_ADDR;
               s_axi.arready <= s_axi.rlast;
               r_addr <= ADDR_W'(next_addr(64'(r_addr), r_size, r_burst));
               r_cnt <= r_cnt + 8'd1;
            end
            default: rs <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: randomized scoreboard bench against a byte-level reference memory
module tb_axi_mem_responder;
   localparam int ID_W = 4;
   localparam int ADDR_W = 36;
   localparam int DL = 12;
   localparam int DEPTH = 1 << DL;
   localparam logic [35:0] BASE = 36'h8_0000_0000;
   localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10;

   typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} b_exp_t;
   typedef struct {logic [ID_W-1:0] id; logic [63:0] data; logic [63:0] mask; logic [1:0] resp; logic last;} r_exp_t;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) s ();
   axi_mem_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .BASE(BASE), .DEPTH_LOG2(DL)) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .s_axi(s)
   );

   b_exp_t bq[$];
   r_exp_t rq[$];
   logic [63:0] mdata [int];
   logic [7:0] mknown [int];
   logic [63:0] wdat [256];
   logic [7:0] wstb [256];
   int total = 0;
   int bad = 0;
   int rbeats = 0;
   int bmode = 0;
   int rmode = 0;
   b_exp_t mb;
   r_exp_t mr;

   function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endfunction

   function automatic bit bad_addr(input logic [35:0] a, input int size, input logic [1:0] burst);
      return a < BASE || a >= BASE + 36'(DEPTH * 8) || burst == WRP || size > 3;
   endfunction

   function automatic logic [63:0] beat_addr(input logic [35:0] a, input int i, input int size, input logic [1:0] burst);
      return 64'(a) + ((burst == FIX) ? 64'd0 : (64'(i) << size));
   endfunction

   function automatic int widx(input logic [63:0] ba);
      return int'(((ba - 64'(BASE)) >> 3) % DEPTH);
   endfunction

   function automatic logic [63:0] bmask(input logic [7:0] b);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{b[i]}};
      return m;
   endfunction

   function automatic void mwrite(input int ix, input logic [63:0] d, input logic [7:0] b);
      logic [63:0] v = mdata.exists(ix) ? mdata[ix] : 64'd0;
      logic [7:0] k = mknown.exists(ix) ? mknown[ix] : 8'd0;
      for (int i = 0; i < 8; i++)
         if (b[i]) begin
            v[i*8 +: 8] = d[i*8 +: 8];
            k[i] = 1'b1;
         end
      mdata[ix] = v;
      mknown[ix] = k;
   endfunction

   // monitor: pops one expectation for every handshake the DUT completes
   always @(negedge aclk) begin
      if (aresetn) begin
         if (s.bvalid && s.bready) begin
            if (bq.size() == 0) chk("b_unexpected", 64'(bq.size()), 64'd1);
            else begin
               mb = bq.pop_front();
               chk("bid", 64'(s.bid), 64'(mb.id));
               chk("bresp", 64'(s.bresp), 64'(mb.resp));
            end
         end
         if (s.rvalid && s.rready) begin
            rbeats++;
            if (rq.size() == 0) chk("r_unexpected", 64'(rq.size()), 64'd1);
            else begin
               mr = rq.pop_front();
               chk("rid", 64'(s.rid), 64'(mr.id));
               chk("rdata", s.rdata & mr.mask, mr.data & mr.mask);
               chk("rresp", 64'(s.rresp), 64'(mr.resp));
               chk("rlast", 64'(s.rlast), 64'(mr.last));
            end
         end
      end
   end

   // ready drivers: 0 random, 1 held low, 2 held high
   initial forever begin
      @(posedge aclk);
      #1;
      s.bready = bmode == 2 || (bmode == 0 && $urandom_range(0, 3) != 0);
      s.rready = rmode == 2 || (rmode == 0 && $urandom_range(0, 3) != 0);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic hs(input int w, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 100) begin
         @(negedge aclk);
         ok = (w == 0) ? s.awready : (w == 1) ? s.wready : s.arready;
         @(posedge aclk);
         #1;
         n++;
      end
   endtask

   task automatic issue_write(input logic [ID_W-1:0] id, input logic [35:0] a, input int len, input int size,
                              input logic [1:0] burst, input int nb);
      int k;
      bit err, ok;
      b_exp_t e;
      k = (nb < len + 1) ? nb : len + 1;
      err = bad_addr(a, size, burst);
      e.id = id;
      e.resp = err ? 2'b11 : (nb == len + 1) ? 2'b00 : 2'b10;
      bq.push_back(e);
      s.awid = id;
      s.awaddr = a;
      s.awlen = 8'(len);
      s.awsize = 3'(size);
      s.awburst = burst;
      s.awvalid = 1'b1;
      hs(0, ok);
      chk("aw_accept", 64'(ok), 64'd1);
      s.awvalid = 1'b0;
      for (int i = 0; i < k; i++) begin
         if (!err) mwrite(widx(beat_addr(a, i, size, burst)), wdat[i], wstb[i]);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge aclk);
            #1;
         end
         s.wdata = wdat[i];
         s.wstrb = wstb[i];
         s.wlast = (i == nb - 1);
         s.wvalid = 1'b1;
         hs(1, ok);
         chk("w_accept", 64'(ok), 64'd1);
         s.wvalid = 1'b0;
         s.wlast = 1'b0;
      end
   endtask

   task automatic issue_read(input logic [ID_W-1:0] id, input logic [35:0] a, input int len, input int size,
                             input logic [1:0] burst, input bit lat);
      bit err, ok;
      int ix;
      r_exp_t e;
      err = bad_addr(a, size, burst);
      for (int i = 0; i <= len; i++) begin
         ix = widx(beat_addr(a, i, size, burst));
         e.id = id;
         e.resp = err ? 2'b11 : 2'b00;
         e.last = (i == len);
         e.data = err ? 64'd0 : mdata.exists(ix) ? mdata[ix] : 64'd0;
         e.mask = err ? '1 : mknown.exists(ix) ? bmask(mknown[ix]) : 64'd0;
         rq.push_back(e);
      end
      s.arid = id;
      s.araddr = a;
      s.arlen = 8'(len);
      s.arsize = 3'(size);
      s.arburst = burst;
      s.arvalid = 1'b1;
      hs(2, ok);
      chk("ar_accept", 64'(ok), 64'd1);
      s.arvalid = 1'b0;
      if (lat) begin
         @(negedge aclk);
         chk("latency_cycle1_rvalid", 64'(s.rvalid), 64'd0);
         @(negedge aclk);
         chk("latency_cycle2_rvalid", 64'(s.rvalid), 64'd1);
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic wait_b();
      int n = 0;
      while (bq.size() != 0 && n < 300) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("b_drain", 64'(bq.size()), 64'd0);
   endtask

   task automatic wait_r();
      int n = 0;
      while (rq.size() != 0 && n < 600) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("r_drain", 64'(rq.size()), 64'd0);
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) begin
         wdat[i] = {$urandom, $urandom};
         wstb[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      end
   endtask

   initial begin
      int n, len, size, r, nb, rb0;
      bit stable, acc;
      logic [35:0] a;
      logic [1:0] burst;
      logic [63:0] hd;
      logic [ID_W+2:0] hb;
      {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst, s.awlock, s.awcache, s.awprot, s.awqos, s.awvalid} = '0;
      {s.wdata, s.wstrb, s.wlast, s.wvalid} = '0;
      {s.arid, s.araddr, s.arlen, s.arsize, s.arburst, s.arlock, s.arcache, s.arprot, s.arqos, s.arvalid} = '0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_awready", 64'(s.awready), 64'd1);
      chk("rst_arready", 64'(s.arready), 64'd1);
      chk("rst_wready", 64'(s.wready), 64'd0);
      chk("rst_bvalid", 64'(s.bvalid), 64'd0);
      chk("rst_rvalid", 64'(s.rvalid), 64'd0);
      chk("rst_bid_bresp", 64'({s.bid, s.bresp}), 64'd0);
      chk("rst_rid_rresp_rlast", 64'({s.rid, s.rresp, s.rlast}), 64'd0);
      chk("rst_rdata", s.rdata, 64'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      // single beat write then read with latency check
      wdat[0] = 64'h1122334455667788;
      wstb[0] = 8'hFF;
      issue_write(4'h3, BASE + 36'h10, 0, 3, INC, 1);
      wait_b();
      issue_read(4'h5, BASE + 36'h10, 0, 3, INC, 1'b1);
      wait_r();
      // INCR burst then FIXED read of the second word
      for (int i = 0; i < 4; i++) begin
         wdat[i] = 64'(i);
         wstb[i] = 8'hFF;
      end
      issue_write(4'h1, BASE + 36'h100, 3, 3, INC, 4);
      wait_b();
      issue_read(4'hA, BASE + 36'h108, 3, 3, FIX, 1'b0);
      wait_r();
      // byte strobes
      wdat[0] = '1;
      wstb[0] = 8'hFF;
      issue_write(4'h2, BASE + 36'h200, 0, 3, INC, 1);
      wait_b();
      wdat[0] = '0;
      wstb[0] = 8'h0F;
      issue_write(4'h2, BASE + 36'h200, 0, 3, INC, 1);
      wait_b();
      issue_read(4'h2, BASE + 36'h200, 0, 3, INC, 1'b0);
      wait_r();
      // out of window: nothing written, reads return DECERR zeros
      wdat[0] = 64'hDEAD_BEEF_0000_0001;
      wstb[0] = 8'hFF;
      issue_write(4'h4, BASE, 0, 3, INC, 1);
      wait_b();
      fill_rand(2);
      issue_write(4'h6, 36'h1_0000_0000, 1, 3, INC, 2);
      wait_b();
      issue_read(4'h6, 36'h1_0000_0000, 1, 3, INC, 1'b0);
      wait_r();
      issue_read(4'h7, BASE, 0, 3, INC, 1'b0);
      wait_r();
      // wlast early and wlast missing
      fill_rand(4);
      issue_write(4'h8, BASE + 36'h400, 3, 3, INC, 2);
      wait_b();
      fill_rand(2);
      issue_write(4'h9, BASE + 36'h500, 1, 3, INC, 5);
      wait_b();
      issue_read(4'h8, BASE + 36'h400, 3, 3, INC, 1'b0);
      wait_r();
      issue_read(4'h9, BASE + 36'h500, 1, 3, INC, 1'b0);
      wait_r();
      // burst crossing the window end wraps to word 0
      fill_rand(2);
      wstb[0] = 8'hFF;
      wstb[1] = 8'hFF;
      issue_write(4'hB, BASE + 36'((DEPTH - 1) * 8), 1, 3, INC, 2);
      wait_b();
      issue_read(4'hB, BASE + 36'((DEPTH - 1) * 8), 1, 3, INC, 1'b0);
      wait_r();
      issue_read(4'hC, BASE, 0, 3, INC, 1'b0);
      wait_r();
      // WRAP and oversize are decode errors
      fill_rand(2);
      issue_write(4'hD, BASE + 36'h600, 1, 3, WRP, 2);
      wait_b();
      issue_write(4'hD, BASE + 36'h600, 0, 4, INC, 1);
      wait_b();
      issue_read(4'hE, BASE + 36'h600, 1, 3, WRP, 1'b0);
      wait_r();
      issue_read(4'hE, BASE + 36'h600, 0, 3, INC, 1'b0);
      wait_r();
      // B backpressure
      bmode = 1;
      fill_rand(2);
      issue_write(4'h9, BASE + 36'h300, 1, 3, INC, 2);
      n = 0;
      while (!s.bvalid && n < 50) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("b_seen", 64'(s.bvalid), 64'd1);
      hb = {s.bid, s.bresp, s.bvalid};
      s.awaddr = BASE;
      s.awlen = 0;
      s.awvalid = 1'b1;
      stable = 1'b1;
      acc = 1'b0;
      repeat (10) begin
         @(negedge aclk);
         if ({s.bid, s.bresp, s.bvalid} !== hb) stable = 1'b0;
         if (s.awready) acc = 1'b1;
      end
      @(posedge aclk);
      #1;
      s.awvalid = 1'b0;
      chk("b_hold_stable", 64'(stable), 64'd1);
      chk("aw_blocked_during_b", 64'(acc), 64'd0);
      bmode = 0;
      wait_b();
      // R backpressure
      rmode = 1;
      issue_read(4'h3, BASE + 36'h300, 1, 3, INC, 1'b0);
      n = 0;
      while (!s.rvalid && n < 50) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("r_seen", 64'(s.rvalid), 64'd1);
      hd = s.rdata;
      hb = {s.rid, s.rresp, s.rlast};
      s.araddr = BASE;
      s.arlen = 0;
      s.arvalid = 1'b1;
      stable = 1'b1;
      acc = 1'b0;
      repeat (10) begin
         @(negedge aclk);
         if (!s.rvalid || s.rdata !== hd || {s.rid, s.rresp, s.rlast} !== hb) stable = 1'b0;
         if (s.arready) acc = 1'b1;
      end
      @(posedge aclk);
      #1;
      s.arvalid = 1'b0;
      chk("r_hold_stable", 64'(stable), 64'd1);
      chk("ar_blocked_during_r", 64'(acc), 64'd0);
      rmode = 0;
      wait_r();
      // randomized traffic
      for (int t = 0; t < 70; t++) begin
         len = $urandom_range(0, 7);
         r = $urandom_range(0, 9);
         size = (r < 6) ? 3 : r - 6;
         if ($urandom_range(0, 19) == 0) size = 4;
         r = $urandom_range(0, 9);
         burst = (r < 6) ? INC : (r < 9) ? FIX : WRP;
         r = $urandom_range(0, 9);
         a = (r < 8) ? BASE + 36'($urandom_range(0, 63) * 8) + 36'((size < 3) ? $urandom_range(0, 7) : 0)
           : (r == 8) ? BASE + 36'(DEPTH * 8) + 36'($urandom_range(0, 15) * 8) : BASE - 36'd8;
         if ($urandom_range(0, 1) == 1) begin
            fill_rand(len + 1);
            nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : len + 1;
            issue_write(ID_W'($urandom), a, len, size, burst, nb);
            wait_b();
         end else begin
            issue_read(ID_W'($urandom), a, len, size, burst, 1'b0);
            wait_r();
         end
      end
      // reset during beat 2 of a long read
      rmode = 2;
      rb0 = rbeats;
      issue_read(4'h7, BASE + 36'h100, 7, 3, INC, 1'b0);
      n = 0;
      while (!(s.rvalid && rbeats == rb0 + 1) && n < 50) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("reset_reached_beat2", 64'(rbeats - rb0), 64'd1);
      aresetn = 1'b0;
      #1;
      chk("reset_rvalid_async", 64'(s.rvalid), 64'd0);
      rq.delete();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("post_reset_arready", 64'(s.arready), 64'd1);
      chk("post_reset_rvalid", 64'(s.rvalid), 64'd0);
      @(posedge aclk);
      #1;
      rmode = 0;
      issue_read(4'h2, BASE + 36'h100, 3, 3, INC, 1'b1);
      wait_r();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
